// File: rtl/lpif_dstrm_rx_buffer_pkg.sv
// Shared types for the LPIF downstream receive buffer: FSM states, the packed
// FIFO word and a saturating counter helper.
package lpif_rx_pkg;

  localparam int LANE_W = 32;

  typedef enum logic [1:0] {
    OFFLINE = 2'd0,
    ACTIVE  = 2'd1,
    DRAIN   = 2'd2
  } rx_fsm_e;

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  protid;
    logic        half;
    logic        crc_err;
  } rx_word_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] base, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, base} + {15'd0, inc};
    if (sum[16]) begin
      return 16'hFFFF;
    end else begin
      return sum[15:0];
    end
  endfunction

endpackage

// File: rtl/lpif_dstrm_rx_buffer_fifo.sv
// Two-write / one-read FIFO with first-word fall-through output. Write port 1
// is ordered after port 0 and a same-cycle pop frees its entry for the writes.
module lpif_rx_fifo_2w1r
  import lpif_rx_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en0,
  input  rx_word_t      wr_word0,
  input  logic          wr_en1,
  input  rx_word_t      wr_word1,
  output logic          wr_acc0,
  output logic          wr_acc1,
  output logic          rd_valid,
  output rx_word_t      rd_word,
  input  logic          rd_ready,
  output logic [CW-1:0] occupancy
);

  rx_word_t        mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            pop_s;
  logic [CW:0]     free_s;
  logic [AW-1:0]   wr_idx1_s;

  assign rd_valid  = (count_r != {CW{1'b0}});
  assign rd_word   = mem_r[rd_ptr_r];
  assign occupancy = count_r;
  assign pop_s     = rd_valid & rd_ready;

  // Free slots seen by this cycle's writes, counting the entry a pop releases.
  always_comb begin
    free_s    = (CW + 1)'(DEPTH) - {1'b0, count_r} + {{CW{1'b0}}, pop_s};
    wr_acc0   = wr_en0 & (free_s >= (CW + 1)'(1));
    wr_acc1   = wr_en1 & (free_s >= (wr_acc0 ? (CW + 1)'(2) : (CW + 1)'(1)));
    wr_idx1_s = wr_ptr_r + {{(AW - 1){1'b0}}, wr_acc0};
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (wr_acc0) begin
        mem_r[wr_ptr_r] <= wr_word0;
      end
      if (wr_acc1) begin
        mem_r[wr_idx1_s] <= wr_word1;
      end
      wr_ptr_r <= wr_ptr_r + AW'(wr_acc0) + AW'(wr_acc1);
      rd_ptr_r <= rd_ptr_r + AW'(pop_s);
      count_r  <= count_r + CW'(wr_acc0) + CW'(wr_acc1) - CW'(pop_s);
    end
  end

endmodule

// File: rtl/lpif_dstrm_rx_buffer.sv
// LPIF downstream receive buffer: packs 32-bit lanes into tagged 64-bit words,
// queues them in a FIFO, tracks link state and keeps error statistics.
module lpif_dstrm_rx_buffer
  import lpif_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_wr,
  input  logic        rst_wr_n,
  input  logic        rx_online,
  input  logic [7:0]  dstrm_state,
  input  logic [3:0]  dstrm_protid,
  input  logic [63:0] dstrm_data,
  input  logic [1:0]  dstrm_dvalid,
  input  logic [1:0]  dstrm_crc,
  input  logic [1:0]  dstrm_crc_valid,
  input  logic [1:0]  dstrm_valid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [3:0]  out_protid,
  output logic        out_half,
  output logic        out_crc_err,
  output logic [7:0]  link_state,
  output logic        state_chg,
  output logic        ovfl_sticky,
  output logic [15:0] crc_err_cnt,
  output logic [15:0] drop_cnt,
  input  logic        clr_status
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rx_fsm_e             state_r, state_s;
  logic                res_v_r, res_v_s;
  logic [LANE_W-1:0]   res_data_r, res_data_s;
  logic [3:0]          res_pid_r, res_pid_s;
  logic                res_crc_r, res_crc_s;

  logic [1:0]          lane_acc_s, crc_fail_s;
  logic                drain_entry_s, res_full_s, flush_s, lane_push_s;
  logic [LANE_W-1:0]   la_data_s, lb_data_s;
  logic                la_crc_s, lb_crc_s;
  rx_word_t            half_word_s, lane_word_s, push0_w_s, push1_w_s, head_s;
  logic                push0_v_s, push1_v_s, acc0_s, acc1_s;
  logic [CW-1:0]       occ_s;
  logic [1:0]          drop_inc_s, crc_inc_s;

  // Lanes are taken only while ACTIVE with the link still up; the cycle the
  // link drops is spent flushing the residual instead.
  assign drain_entry_s = (state_r == ACTIVE) & ~rx_online;
  assign lane_acc_s    = {2{(state_r == ACTIVE) & rx_online}} & dstrm_valid & dstrm_dvalid;
  assign crc_fail_s    = dstrm_crc_valid & dstrm_crc;
  assign half_word_s   = '{data: {32'd0, res_data_r}, protid: res_pid_r, half: 1'b1, crc_err: res_crc_r};

  // Earliest accepted lane in la, second (only with both lanes) in lb.
  always_comb begin
    lb_data_s = dstrm_data[63:32];
    lb_crc_s  = crc_fail_s[1];
    if (lane_acc_s == 2'b10) begin
      la_data_s = dstrm_data[63:32];
      la_crc_s  = crc_fail_s[1];
    end else begin
      la_data_s = dstrm_data[31:0];
      la_crc_s  = crc_fail_s[0];
    end
  end

  // Packer: residual update and up to two ordered pushes per cycle.
  always_comb begin
    res_v_s     = res_v_r;
    res_data_s  = res_data_r;
    res_pid_s   = res_pid_r;
    res_crc_s   = res_crc_r;
    flush_s     = 1'b0;
    res_full_s  = res_v_r;
    lane_push_s = 1'b0;
    lane_word_s = '0;
    if (drain_entry_s) begin
      flush_s = res_v_r;
      res_v_s = 1'b0;
    end else if (lane_acc_s != 2'b00) begin
      if (res_v_r && (dstrm_protid != res_pid_r)) begin
        flush_s    = 1'b1;
        res_full_s = 1'b0;
      end else begin
        res_full_s = res_v_r;
      end
      case ({&lane_acc_s, res_full_s})
        2'b00: begin
          res_v_s    = 1'b1;
          res_data_s = la_data_s;
          res_pid_s  = dstrm_protid;
          res_crc_s  = la_crc_s;
        end
        2'b01: begin
          lane_push_s = 1'b1;
          lane_word_s = '{data: {la_data_s, res_data_r}, protid: dstrm_protid, half: 1'b0,
                          crc_err: la_crc_s | res_crc_r};
          res_v_s     = 1'b0;
        end
        2'b10: begin
          lane_push_s = 1'b1;
          lane_word_s = '{data: {lb_data_s, la_data_s}, protid: dstrm_protid, half: 1'b0,
                          crc_err: la_crc_s | lb_crc_s};
          res_v_s     = 1'b0;
        end
        2'b11: begin
          lane_push_s = 1'b1;
          lane_word_s = '{data: {la_data_s, res_data_r}, protid: dstrm_protid, half: 1'b0,
                          crc_err: la_crc_s | res_crc_r};
          res_v_s     = 1'b1;
          res_data_s  = lb_data_s;
          res_pid_s   = dstrm_protid;
          res_crc_s   = lb_crc_s;
        end
        default: begin
          res_v_s = 1'b0;
        end
      endcase
    end else begin
      flush_s = 1'b0;
    end
    if (flush_s) begin
      push0_v_s = 1'b1;
      push0_w_s = half_word_s;
      push1_v_s = lane_push_s;
      push1_w_s = lane_word_s;
    end else begin
      push0_v_s = lane_push_s;
      push0_w_s = lane_word_s;
      push1_v_s = 1'b0;
      push1_w_s = '0;
    end
  end

  // FSM next state.
  always_comb begin
    state_s = state_r;
    case (state_r)
      OFFLINE: begin
        if (rx_online) begin
          state_s = ACTIVE;
        end else begin
          state_s = OFFLINE;
        end
      end
      ACTIVE: begin
        if (!rx_online) begin
          state_s = DRAIN;
        end else begin
          state_s = ACTIVE;
        end
      end
      DRAIN: begin
        if (occ_s == {CW{1'b0}}) begin
          state_s = OFFLINE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: state_s = OFFLINE;
    endcase
  end

  lpif_rx_fifo_2w1r #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_wr),
    .rst_n    (rst_wr_n),
    .wr_en0   (push0_v_s),
    .wr_word0 (push0_w_s),
    .wr_en1   (push1_v_s),
    .wr_word1 (push1_w_s),
    .wr_acc0  (acc0_s),
    .wr_acc1  (acc1_s),
    .rd_valid (out_valid),
    .rd_word  (head_s),
    .rd_ready (out_ready),
    .occupancy(occ_s)
  );

  assign out_data    = head_s.data;
  assign out_protid  = head_s.protid;
  assign out_half    = head_s.half;
  assign out_crc_err = head_s.crc_err;

  assign drop_inc_s = {1'b0, push0_v_s & ~acc0_s} + {1'b0, push1_v_s & ~acc1_s};
  assign crc_inc_s  = {1'b0, crc_fail_s[0]} + {1'b0, crc_fail_s[1]};

  // FSM and residual registers.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      state_r    <= OFFLINE;
      res_v_r    <= 1'b0;
      res_data_r <= {LANE_W{1'b0}};
      res_pid_r  <= 4'd0;
      res_crc_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      res_v_r    <= res_v_s;
      res_data_r <= res_data_s;
      res_pid_r  <= res_pid_s;
      res_crc_r  <= res_crc_s;
    end
  end

  // Link state capture and change pulse.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      link_state <= 8'd0;
      state_chg  <= 1'b0;
    end else if (|dstrm_valid) begin
      link_state <= dstrm_state;
      state_chg  <= (dstrm_state != link_state);
    end else begin
      state_chg  <= 1'b0;
    end
  end

  // Error statistics; a clear wins over any increment in the same cycle.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      ovfl_sticky <= 1'b0;
      crc_err_cnt <= 16'd0;
      drop_cnt    <= 16'd0;
    end else if (clr_status) begin
      ovfl_sticky <= 1'b0;
      crc_err_cnt <= 16'd0;
      drop_cnt    <= 16'd0;
    end else begin
      ovfl_sticky <= ovfl_sticky | (drop_inc_s != 2'd0);
      crc_err_cnt <= sat_add16(crc_err_cnt, crc_inc_s);
      drop_cnt    <= sat_add16(drop_cnt, drop_inc_s);
    end
  end

endmodule

// File: tb/tb_lpif_dstrm_rx_buffer.sv
// Bench for lpif_dstrm_rx_buffer: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a lane-level model.
module tb_lpif_dstrm_rx_buffer;

  localparam int DEPTH = 8;
  localparam int M_OFF = 0, M_ACT = 1, M_DRN = 2;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  pid;
    logic        crc;
  } lane_t;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  pid;
    logic        half;
    logic        crc;
  } mw_t;

  logic        clk_wr = 1'b0;
  logic        rst_wr_n = 1'b0;
  logic        rx_online = 1'b0;
  logic [7:0]  dstrm_state = 8'd0;
  logic [3:0]  dstrm_protid = 4'd0;
  logic [63:0] dstrm_data = 64'd0;
  logic [1:0]  dstrm_dvalid = 2'b00;
  logic [1:0]  dstrm_crc = 2'b00;
  logic [1:0]  dstrm_crc_valid = 2'b00;
  logic [1:0]  dstrm_valid = 2'b00;
  logic        out_ready = 1'b1;
  logic        clr_status = 1'b0;
  logic        out_valid, out_half, out_crc_err, state_chg, ovfl_sticky;
  logic [63:0] out_data;
  logic [3:0]  out_protid;
  logic [7:0]  link_state;
  logic [15:0] crc_err_cnt, drop_cnt;

  lpif_dstrm_rx_buffer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .rx_online(rx_online),
    .dstrm_state(dstrm_state), .dstrm_protid(dstrm_protid), .dstrm_data(dstrm_data),
    .dstrm_dvalid(dstrm_dvalid), .dstrm_crc(dstrm_crc), .dstrm_crc_valid(dstrm_crc_valid),
    .dstrm_valid(dstrm_valid), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_protid(out_protid), .out_half(out_half),
    .out_crc_err(out_crc_err), .link_state(link_state), .state_chg(state_chg),
    .ovfl_sticky(ovfl_sticky), .crc_err_cnt(crc_err_cnt), .drop_cnt(drop_cnt),
    .clr_status(clr_status)
  );

  always #5 clk_wr = ~clk_wr;

  int n_vec = 0;
  int n_err = 0;

  // model state
  mw_t         m_q[$];
  lane_t       m_res;
  logic        m_res_v;
  int          m_mode;
  logic [7:0]  m_link;
  logic        m_chg, m_sticky;
  int          m_crc_cnt, m_drop_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    m_res = '{32'd0, 4'd0, 1'b0};
    m_res_v = 1'b0;
    m_mode = M_OFF;
    m_link = 8'd0;
    m_chg = 1'b0;
    m_sticky = 1'b0;
    m_crc_cnt = 0;
    m_drop_cnt = 0;
  endtask

  function automatic mw_t half_of(input lane_t r);
    return '{{32'd0, r.data}, r.pid, 1'b1, r.crc};
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    lane_t ln[$];
    mw_t   pw[$];
    int    pre_sz;
    int    drops;
    logic [1:0] fails;
    pre_sz = m_q.size();
    fails = dstrm_crc_valid & dstrm_crc;
    if (m_mode == M_ACT && !rx_online) begin
      if (m_res_v) pw.push_back(half_of(m_res));
      m_res_v = 1'b0;
    end else if (m_mode == M_ACT) begin
      for (int i = 0; i < 2; i++)
        if (dstrm_valid[i] && dstrm_dvalid[i])
          ln.push_back('{dstrm_data[32*i +: 32], dstrm_protid, fails[i]});
      if (ln.size() > 0 && m_res_v && m_res.pid != dstrm_protid) begin
        pw.push_back(half_of(m_res));
        m_res_v = 1'b0;
      end
      foreach (ln[k]) begin
        if (!m_res_v) begin
          m_res = ln[k];
          m_res_v = 1'b1;
        end else begin
          pw.push_back('{{ln[k].data, m_res.data}, ln[k].pid, 1'b0, ln[k].crc | m_res.crc});
          m_res_v = 1'b0;
        end
      end
    end
    if (out_ready && pre_sz > 0) void'(m_q.pop_front());
    drops = 0;
    foreach (pw[k]) begin
      if (m_q.size() < DEPTH) m_q.push_back(pw[k]);
      else drops++;
    end
    if (clr_status) begin
      m_crc_cnt = 0;
      m_drop_cnt = 0;
      m_sticky = 1'b0;
    end else begin
      m_crc_cnt = m_crc_cnt + int'(fails[0]) + int'(fails[1]);
      if (m_crc_cnt > 65535) m_crc_cnt = 65535;
      m_drop_cnt = m_drop_cnt + drops;
      if (m_drop_cnt > 65535) m_drop_cnt = 65535;
      if (drops > 0) m_sticky = 1'b1;
    end
    if (|dstrm_valid) begin
      m_chg = (dstrm_state != m_link);
      m_link = dstrm_state;
    end else begin
      m_chg = 1'b0;
    end
    case (m_mode)
      M_OFF: if (rx_online) m_mode = M_ACT;
      M_ACT: if (!rx_online) m_mode = M_DRN;
      default: if (pre_sz == 0) m_mode = M_OFF;
    endcase
  endtask

  task automatic compare_all();
    mw_t h;
    logic [63:0] mask;
    chk("out_valid", out_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      h = m_q[0];
      mask = h.half ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
      chk("out_data", out_data & mask, h.data & mask);
      chk("out_protid", out_protid, h.pid);
      chk("out_half", out_half, h.half);
      chk("out_crc_err", out_crc_err, h.crc);
    end
    chk("link_state", link_state, m_link);
    chk("state_chg", state_chg, m_chg);
    chk("ovfl_sticky", ovfl_sticky, m_sticky);
    chk("crc_err_cnt", crc_err_cnt, 64'(m_crc_cnt));
    chk("drop_cnt", drop_cnt, 64'(m_drop_cnt));
  endtask

  // One clock: model consumes the driven inputs, outputs compared mid-cycle.
  task automatic tick();
    if (rst_wr_n) model_step();
    @(negedge clk_wr);
    if (rst_wr_n) compare_all();
    #1;
  endtask

  task automatic lanes(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [3:0] pid);
    dstrm_valid = v;
    dstrm_dvalid = v;
    dstrm_data = {d1, d0};
    dstrm_protid = pid;
  endtask

  task automatic idle();
    dstrm_valid = 2'b00;
    dstrm_dvalid = 2'b00;
  endtask

  initial begin
    m_reset();
    @(negedge clk_wr);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_link", link_state, 8'd0);
    rst_wr_n = 1'b1;
    rx_online = 1'b1;
    tick();

    // single lanes
    lanes(2'b01, 32'hA, 32'h0, 4'd3); tick();
    lanes(2'b01, 32'hB, 32'h0, 4'd3); tick();
    chk("single_data", out_data, 64'h0000000B_0000000A);
    chk("single_half", out_half, 1'b0);
    chk("single_pid", out_protid, 4'd3);
    idle(); tick();

    // mixed lane counts
    lanes(2'b01, 32'h1, 32'h0, 4'd3); tick();
    lanes(2'b11, 32'h2, 32'h3, 4'd3); tick();
    chk("mixed_w0", out_data, 64'h00000002_00000001);
    lanes(2'b01, 32'h4, 32'h0, 4'd3); tick();
    chk("mixed_w1", out_data, 64'h00000004_00000003);
    idle(); tick();

    // protid change while residual is full
    lanes(2'b01, 32'h5, 32'h0, 4'd1); tick();
    lanes(2'b11, 32'h6, 32'h7, 4'd2); tick();
    chk("pid_half", out_half, 1'b1);
    chk("pid_half_data", out_data[31:0], 32'h5);
    chk("pid_half_pid", out_protid, 4'd1);
    idle(); tick();
    chk("pid_full_data", out_data, 64'h00000007_00000006);
    chk("pid_full_pid", out_protid, 4'd2);
    idle(); tick();

    // overflow
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      lanes(2'b11, 32'(i), 32'(i + 100), 4'd2);
      tick();
    end
    idle();
    chk("ovfl_sticky", ovfl_sticky, 1'b1);
    chk("ovfl_drops", drop_cnt, 16'd3);
    clr_status = 1'b1; tick(); clr_status = 1'b0;
    chk("clr_sticky", ovfl_sticky, 1'b0);
    chk("clr_drops", drop_cnt, 16'd0);
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) tick();

    // drain
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      lanes(2'b11, 32'(i + 16), 32'(i + 32), 4'd2);
      tick();
    end
    lanes(2'b01, 32'h99, 32'h0, 4'd2); tick();
    idle(); rx_online = 1'b0; tick();
    out_ready = 1'b1;
    lanes(2'b11, 32'hDEAD, 32'hBEEF, 4'd2);
    for (int i = 0; i < 3; i++) tick();
    chk("drain_half", out_half, 1'b1);
    chk("drain_half_data", out_data[31:0], 32'h99);
    tick();
    chk("drain_empty", out_valid, 1'b0);
    tick(); tick();
    chk("offline_ignored", out_valid, 1'b0);
    idle(); rx_online = 1'b1; tick();

    // CRC and link state
    lanes(2'b11, 32'h11, 32'h22, 4'd2);
    dstrm_crc = 2'b11; dstrm_crc_valid = 2'b11; tick();
    dstrm_crc = 2'b00; dstrm_crc_valid = 2'b00;
    chk("crc_cnt", crc_err_cnt, 16'd2);
    chk("crc_word", out_crc_err, 1'b1);
    idle(); tick();
    dstrm_valid = 2'b01; dstrm_state = 8'd3; tick();
    chk("link_3", link_state, 8'd3);
    chk("chg_pulse", state_chg, 1'b1);
    tick();
    chk("chg_once", state_chg, 1'b0);
    idle(); tick();

    // randomized traffic with one asynchronous reset in the middle
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) begin
        rst_wr_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 1'b0);
        chk("async_rst_drop", drop_cnt, 16'd0);
        m_reset();
        tick(); tick();
        rst_wr_n = 1'b1;
      end
      if ($urandom_range(0, 99) < 2) rx_online = ~rx_online;
      dstrm_valid = 2'($urandom);
      dstrm_dvalid = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom);
      dstrm_data = {$urandom, $urandom};
      if ($urandom_range(0, 9) == 0) dstrm_protid = 4'($urandom_range(0, 3));
      dstrm_crc_valid = 2'($urandom);
      dstrm_crc = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      if ($urandom_range(0, 15) == 0) dstrm_state = 8'($urandom_range(0, 3));
      out_ready = ((i % 500) < 120) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      clr_status = ($urandom_range(0, 199) == 0);
      tick();
    end

    // CRC counter saturation and clear priority
    idle(); clr_status = 1'b1; dstrm_crc = 2'b00; tick(); clr_status = 1'b0;
    dstrm_crc = 2'b11; dstrm_crc_valid = 2'b11;
    for (int i = 0; i < 32770; i++) tick();
    chk("crc_sat", crc_err_cnt, 16'hFFFF);
    clr_status = 1'b1; tick(); clr_status = 1'b0;
    chk("clr_priority", crc_err_cnt, 16'd0);
    dstrm_crc = 2'b00; tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
